// File: rtl/dot_matrix_sequencer.sv
// Row-scan driver for an LED dot-matrix: scans ROWS lines continuously, fetches glyph rows
// from an external combinational ROM and sequences glyphs in step/hold/scroll/blank modes.
module dot_matrix_sequencer #(
    parameter int ROWS          = 16,
    parameter int COLS          = 16,
    parameter int NUM_GLYPHS    = 3,
    parameter int DWELL_FRAMES  = 32,
    parameter int SCROLL_FRAMES = 4,
    localparam int RW = $clog2(ROWS),
    localparam int GW = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic            pause,
    output logic [GW-1:0]   rom_glyph,
    output logic [RW-1:0]   rom_row,
    input  logic [COLS-1:0] rom_data,
    output logic [RW-1:0]   keyc,
    output logic [COLS-1:0] keyr,
    output logic [GW-1:0]   glyph_idx,
    output logic            frame_tick
);

    localparam int DCW = $clog2(DWELL_FRAMES + 1);
    localparam int SCW = $clog2(SCROLL_FRAMES + 1);
    localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);

    typedef enum logic [1:0] {
        M_STEP   = 2'b00,
        M_HOLD   = 2'b01,
        M_SCROLL = 2'b10,
        M_BLANK  = 2'b11
    } mode_t;

    mode_t          act, act_nxt;
    logic [RW-1:0]  row, row_nxt;
    logic [RW-1:0]  offset, offset_nxt;
    logic [GW-1:0]  glyph, glyph_nxt;
    logic [DCW-1:0] dwell, dwell_nxt;
    logic [SCW-1:0] scnt, scnt_nxt;
    logic           frame_end;
    logic [GW-1:0]  glyph_succ;
    logic [RW:0]    src;

    assign frame_end  = (row == RW'(ROWS - 1));
    assign glyph_succ = (glyph == GW'(NUM_GLYPHS - 1)) ? '0 : glyph + GW'(1);
    // One extra bit so row+offset can run past the bottom of the current glyph.
    assign src        = {1'b0, row} + {1'b0, offset};
    assign glyph_idx  = glyph;

    always_comb begin
        rom_glyph = glyph;
        rom_row   = row;
        if (act == M_SCROLL) begin
            if (src < ROWS_L) begin
                rom_row = src[RW-1:0];
            end else begin
                rom_glyph = glyph_succ;
                rom_row   = RW'(src - ROWS_L);
            end
        end
    end

    always_comb begin
        row_nxt    = frame_end ? '0 : row + RW'(1);
        act_nxt    = act;
        glyph_nxt  = glyph;
        offset_nxt = offset;
        dwell_nxt  = dwell;
        scnt_nxt   = scnt;
        if (frame_end) begin
            // A mode change restarts the timing of the new mode but keeps the glyph on screen.
            if (mode_t'(mode) != act) begin
                act_nxt    = mode_t'(mode);
                dwell_nxt  = '0;
                scnt_nxt   = '0;
                offset_nxt = '0;
            end else if (!pause) begin
                case (act)
                    M_STEP: begin
                        if (dwell == DCW'(DWELL_FRAMES - 1)) begin
                            dwell_nxt = '0;
                            glyph_nxt = glyph_succ;
                        end else begin
                            dwell_nxt = dwell + DCW'(1);
                        end
                    end
                    M_SCROLL: begin
                        if (scnt == SCW'(SCROLL_FRAMES - 1)) begin
                            scnt_nxt = '0;
                            if (offset == RW'(ROWS - 1)) begin
                                offset_nxt = '0;
                                glyph_nxt  = glyph_succ;
                            end else begin
                                offset_nxt = offset + RW'(1);
                            end
                        end else begin
                            scnt_nxt = scnt + SCW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output stage: keyc/keyr trail the ROM address by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            act        <= M_STEP;
            row        <= '0;
            offset     <= '0;
            glyph      <= '0;
            dwell      <= '0;
            scnt       <= '0;
            keyc       <= '0;
            keyr       <= '1;
            frame_tick <= 1'b0;
        end else begin
            act        <= act_nxt;
            row        <= row_nxt;
            offset     <= offset_nxt;
            glyph      <= glyph_nxt;
            dwell      <= dwell_nxt;
            scnt       <= scnt_nxt;
            keyc       <= row;
            keyr       <= (act == M_BLANK) ? '1 : rom_data;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: doc/dot_matrix_sequencer.md
Name: dot_matrix_sequencer

Overview:
- Parametrised row-scan driver for the LED dot-matrix display.
- Scans ROWS lines continuously and reads glyph row data from an external combinational glyph ROM.
- Drives active-low column data to the matrix.
- Sequences NUM_GLYPHS glyphs in one of four modes: step, hold, vertical scroll or blank. A pause input freezes sequencing but not scanning.

Parameters:
- ROWS, 16, scan lines per frame (≥2); RW = clog2(ROWS).
- COLS, 16, pixels per row (width of keyr).
- NUM_GLYPHS, 3, glyphs in the sequence (≥1); GW = max(1, clog2(NUM_GLYPHS)).
- DWELL_FRAMES, 32, frames each glyph is shown in step mode (≥1).
- SCROLL_FRAMES, 4, frames per one-row scroll step in scroll mode (≥1).

Ports:
- clk, in, 1, system clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- mode, in, 2, 00 step / 01 hold / 10 scroll / 11 blank; sampled only at frame boundaries.
- pause, in, 1, 1 freezes the dwell counter, scroll counter, offset and glyph index.
- rom_glyph, out, GW, glyph index presented to the ROM (combinational from state).
- rom_row, out, RW, row index presented to the ROM (combinational from state).
- rom_data, in, COLS, ROM row pattern; 0 = LED on, 1 = off; valid in the same cycle as the address.
- keyc, out, RW, registered row-select (scan line).
- keyr, out, COLS, registered active-low pixel data for keyc.
- glyph_idx, out, GW, current glyph index (registered).
- frame_tick, out, 1, one-cycle pulse in the cycle after row ROWS-1 was addressed.

Behaviour:
- Reset (rst=1 at an edge) clears internal state: scan row=0, glyph=0, offset=0, dwell=0, scroll counter=0, active mode=00.
- Output values under reset: keyc=0, keyr=all ones (dark), glyph_idx=0, frame_tick=0.
- Reset mid-frame or mid-scroll aborts immediately; there is no state carry-over.
- Scan: row counter increments every cycle and wraps ROWS-1→0. Scanning never stops, including under pause and in blank mode.
- Frame end: cycle in which row==ROWS-1. Every mode/dwell/offset update occurs only on a frame-end edge.
- Latency: ROM addressed combinationally from the current row. On the next edge keyc<=row and keyr<=(blank ? all ones : rom_data). keyc and keyr are always mutually aligned, 1 cycle behind rom_row.
- Mode latch: mode is sampled into active mode at frame end.
  - If the sampled value differs from the active mode: dwell=0, scroll counter=0, offset=0; glyph index is kept.
  - The new mode governs the following frame.
- Step (00): at frame end, if pause=0, dwell increments.
  - When dwell==DWELL_FRAMES-1: dwell<=0, glyph<=glyph+1, wrapping NUM_GLYPHS-1→0.
  - rom_glyph=glyph, rom_row=row.
- Hold (01): glyph, dwell and offset frozen; rom addressing as in step.
- Scroll (10):
  - Displayed source line s = row+offset, computed in RW+1 bits.
  - If s<ROWS: rom_glyph=glyph, rom_row=s. Else: rom_glyph=next glyph (wrapping), rom_row=s-ROWS.
  - At frame end, if pause=0, the scroll counter increments. When it reaches SCROLL_FRAMES-1: counter<=0, then
    - offset<ROWS-1: offset<=offset+1;
    - offset==ROWS-1: offset<=0 and glyph advances (wrapping).
  - NUM_GLYPHS=1: next glyph = same glyph.
- Blank (11): rom addressing as hold; keyr forced to all ones; counters frozen.
- pause=1 while mode is being switched: the mode latch still occurs; the counters reset to 0 per the mode-switch rule.
- glyph_idx mirrors the glyph register.
- frame_tick=1 for exactly one cycle per frame, in the cycle after frame end, in every mode.

Test Plan:
- ROWS=16, NUM_GLYPHS=3, DWELL_FRAMES=2; release rst, mode=00 → keyc sequence 0..15 repeats with keyr==rom_data delayed 1 cycle; glyph_idx 0→1 after 32 cycles, →2 after 64, →0 after 96; frame_tick every 16 cycles.
- Assert rst at row 7 of glyph 2 → next cycle keyc=0, keyr=16'hFFFF, glyph_idx=0; sequence restarts from glyph 0, row 0.
- mode=00, pause=1 for 5 frames starting with glyph 1 → glyph_idx stays 1 and keyc keeps scanning. pause=0 → advances to 2 after 2 further frames.
- mode=10, SCROLL_FRAMES=1, glyph 0 → frame k addresses rows k..15 of glyph 0, then rows 0..k-1 of glyph 1. After 16 frames glyph_idx=1 and offset=0. Glyph 2 wraps to glyph 0 as next.
- mode=11 for 3 frames → keyr=16'hFFFF on every cycle, glyph_idx unchanged. Return to 00 → data visible from the frame after the boundary.
- Toggle mode 00→01 mid-frame (row 5) → change takes effect only after row 15, and dwell resets to 0. Toggle back to 00 → glyph holds DWELL_FRAMES full frames before advancing.
